// File: rtl/io_axi_master_pkg.sv
// iwa_io_pkg: shared types and constants for the IO AXI4-Lite master.
package iwa_io_pkg;
    localparam int IO_ADDR_W = 4;
    localparam int IO_DATA_W = 32;
    typedef enum logic [2:0] {IDLE, RD_A, RD_D, WR_AW, WR_B, RESP} io_axi_state_e;
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;
    typedef struct packed {
        logic                   we;
        logic [IO_ADDR_W-1:0]   addr;
        logic [IO_DATA_W-1:0]   wdata;
        logic [IO_DATA_W/8-1:0] wstrb;
    } io_req_t;
    function automatic logic is_err(input logic [1:0] resp);
        return resp == AXI_RESP_SLVERR || resp == AXI_RESP_DECERR;
    endfunction
endpackage

// File: rtl/io_axi_master_if.sv
// io_axi_master_if: core request/response port plus the AXI4-Lite IO bus pins.
interface io_axi_master_if
    import iwa_io_pkg::*;
#(
    parameter int ADDR_W = IO_ADDR_W,
    parameter int DATA_W = IO_DATA_W
);
    logic              REQ_VALID, REQ_READY, REQ_WE;
    logic [ADDR_W-1:0] REQ_ADDR;
    logic [DATA_W-1:0] REQ_WDATA;
    logic [DATA_W/8-1:0] REQ_WSTRB;
    logic              RSP_VALID, RSP_ERR;
    logic [DATA_W-1:0] RSP_RDATA;
    logic [ADDR_W-1:0] ARADDR, AWADDR;
    logic              ARVALID, ARREADY, RVALID, RREADY;
    logic [DATA_W-1:0] RDATA, WDATA;
    logic [1:0]        RRESP, BRESP;
    logic              AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic [DATA_W/8-1:0] WSTRB;
    modport master (
        input  REQ_VALID, REQ_WE, REQ_ADDR, REQ_WDATA, REQ_WSTRB,
        output REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERR,
        output ARADDR, ARVALID, RREADY, AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY,
        input  ARREADY, RDATA, RRESP, RVALID, AWREADY, WREADY, BRESP, BVALID
    );
    modport slave (
        output REQ_VALID, REQ_WE, REQ_ADDR, REQ_WDATA, REQ_WSTRB,
        input  REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERR,
        input  ARADDR, ARVALID, RREADY, AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY,
        output ARREADY, RDATA, RRESP, RVALID, AWREADY, WREADY, BRESP, BVALID
    );
endinterface

// File: rtl/io_axi_master.sv
// io_axi_master: single-outstanding AXI4-Lite master for core IO loads/stores.
// Optional IO_AXI_TIMEOUT_EN aborts a stuck access after TIMEOUT_CYC busy cycles.
module io_axi_master
    import iwa_io_pkg::*;
`ifdef IO_AXI_TIMEOUT_EN
#(
    parameter int TIMEOUT_CYC = 255
)
`endif
(
    input logic             CLK,
    input logic             RST,
    io_axi_master_if.master bus
);
    io_axi_state_e        state_q, state_d;
    io_req_t              req_q, req_d;
    logic                 arvalid_q, arvalid_d, awvalid_q, awvalid_d, wvalid_q, wvalid_d;
    logic                 rready_q, rready_d, bready_q, bready_d, err_q, err_d;
    logic [IO_DATA_W-1:0] rdata_q, rdata_d;
`ifdef IO_AXI_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy;
    assign busy = state_q inside {RD_A, RD_D, WR_AW, WR_B};
`endif

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        arvalid_d = arvalid_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        rready_d  = rready_q;
        bready_d  = bready_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        unique case (state_q)
            IDLE: if (bus.REQ_VALID) begin
                req_d     = '{bus.REQ_WE, bus.REQ_ADDR, bus.REQ_WDATA, bus.REQ_WSTRB};
                state_d   = bus.REQ_WE ? WR_AW : RD_A;
                arvalid_d = !bus.REQ_WE;
                awvalid_d = bus.REQ_WE;
                wvalid_d  = bus.REQ_WE;
            end
            RD_A: if (bus.ARREADY) begin
                arvalid_d = 1'b0;
                rready_d  = 1'b1;
                state_d   = RD_D;
            end
            RD_D: if (bus.RVALID) begin
                rready_d = 1'b0;
                rdata_d  = bus.RDATA;
                err_d    = is_err(bus.RRESP);
                state_d  = RESP;
            end
            WR_AW: begin
                // AW and W channels complete independently, in either order
                awvalid_d = awvalid_q && !bus.AWREADY;
                wvalid_d  = wvalid_q && !bus.WREADY;
                if (!awvalid_d && !wvalid_d) begin
                    bready_d = 1'b1;
                    state_d  = WR_B;
                end
            end
            WR_B: if (bus.BVALID) begin
                bready_d = 1'b0;
                err_d    = is_err(bus.BRESP);
                state_d  = RESP;
            end
            default: state_d = IDLE;
        endcase
`ifdef IO_AXI_TIMEOUT_EN
        cnt_d = state_q == IDLE ? '0 : busy ? cnt_q + 1'b1 : cnt_q;
        if (busy && cnt_q == CW'(TIMEOUT_CYC - 1)) begin
            {arvalid_d, awvalid_d, wvalid_d, rready_d, bready_d} = '0;
            rdata_d = '0;
            err_d   = 1'b1;
            state_d = RESP;
        end
`endif
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            req_q     <= '0;
            arvalid_q <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            rready_q  <= 1'b0;
            bready_q  <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
`ifdef IO_AXI_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            arvalid_q <= arvalid_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            rready_q  <= rready_d;
            bready_q  <= bready_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
`ifdef IO_AXI_TIMEOUT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    assign bus.REQ_READY = state_q == IDLE;
    assign bus.RSP_VALID = state_q == RESP;
    assign bus.RSP_RDATA = (state_q == RESP && !req_q.we) ? rdata_q : '0;
    assign bus.RSP_ERR   = state_q == RESP && err_q;
    assign bus.ARADDR    = req_q.addr;
    assign bus.AWADDR    = req_q.addr;
    assign bus.WDATA     = req_q.wdata;
    assign bus.WSTRB     = req_q.wstrb;
    assign bus.ARVALID   = arvalid_q;
    assign bus.AWVALID   = awvalid_q;
    assign bus.WVALID    = wvalid_q;
    assign bus.RREADY    = rready_q;
    assign bus.BREADY    = bready_q;
endmodule

// File: tb/tb_io_axi_master.sv
// tb_io_axi_master: directed self-checking bench; inputs driven and outputs sampled on negedge.
module tb_io_axi_master;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_cmp = 0, n_err = 0, rsp_cnt = 0, ar_hs = 0;
    always #5 clk = ~clk;

    io_axi_master_if bus();
`ifdef IO_AXI_TIMEOUT_EN
    io_axi_master #(.TIMEOUT_CYC(8)) dut (.CLK(clk), .RST(rst), .bus(bus));
`else
    io_axi_master dut (.CLK(clk), .RST(rst), .bus(bus));
`endif

    always @(posedge clk) begin
        if (bus.RSP_VALID) rsp_cnt <= rsp_cnt + 1;
        if (bus.ARVALID && bus.ARREADY) ar_hs <= ar_hs + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic request(input logic we, input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
        bus.REQ_VALID = 1'b1;
        bus.REQ_WE    = we;
        bus.REQ_ADDR  = a;
        bus.REQ_WDATA = d;
        bus.REQ_WSTRB = s;
        tick;
        bus.REQ_VALID = 1'b0;
    endtask

    initial begin
        int base, base_ar, k;
        bus.REQ_VALID = 0; bus.REQ_WE = 0; bus.REQ_ADDR = '0; bus.REQ_WDATA = '0; bus.REQ_WSTRB = '0;
        bus.ARREADY = 0; bus.RVALID = 0; bus.RDATA = '0; bus.RRESP = '0;
        bus.AWREADY = 0; bus.WREADY = 0; bus.BVALID = 0; bus.BRESP = '0;
        repeat (3) tick;
        check("rst_arvalid", bus.ARVALID, 0);
        check("rst_awvalid", bus.AWVALID, 0);
        check("rst_wvalid", bus.WVALID, 0);
        check("rst_rready", bus.RREADY, 0);
        check("rst_bready", bus.BREADY, 0);
        check("rst_rsp_valid", bus.RSP_VALID, 0);
        check("rst_rsp_rdata", bus.RSP_RDATA, 0);
        check("rst_rsp_err", bus.RSP_ERR, 0);
        check("rst_addr", bus.ARADDR, 0);
        check("rst_wdata", bus.WDATA, 0);
        check("rst_wstrb", bus.WSTRB, 0);
        rst = 1'b0;
        check("rst_req_ready", bus.REQ_READY, 1);

        // read, zero-wait slave: RSP_VALID three cycles after accept
        request(0, 4'h3, 0, 0);
        check("rd_arvalid", bus.ARVALID, 1);
        check("rd_araddr", bus.ARADDR, 4'h3);
        check("rd_req_ready", bus.REQ_READY, 0);
        bus.ARREADY = 1; tick; bus.ARREADY = 0;
        check("rd_arvalid_drop", bus.ARVALID, 0);
        check("rd_rready", bus.RREADY, 1);
        bus.RVALID = 1; bus.RDATA = 32'h1234_5678; bus.RRESP = 2'b00; tick; bus.RVALID = 0;
        check("rd_rsp_valid", bus.RSP_VALID, 1);
        check("rd_rsp_rdata", bus.RSP_RDATA, 32'h1234_5678);
        check("rd_rsp_err", bus.RSP_ERR, 0);
        check("rd_rready_drop", bus.RREADY, 0);
        tick;
        check("rd_rsp_one_cycle", bus.RSP_VALID, 0);
        check("rd_req_ready_back", bus.REQ_READY, 1);

        // write, W handshakes three cycles before AW
        base = rsp_cnt;
        request(1, 4'h8, 32'hA5A5_0001, 4'hF);
        check("wr_awvalid", bus.AWVALID, 1);
        check("wr_wvalid", bus.WVALID, 1);
        check("wr_awaddr", bus.AWADDR, 4'h8);
        check("wr_wdata", bus.WDATA, 32'hA5A5_0001);
        check("wr_wstrb", bus.WSTRB, 4'hF);
        bus.WREADY = 1; tick; bus.WREADY = 0;
        check("wr_wvalid_drop", bus.WVALID, 0);
        repeat (2) begin
            check("wr_awvalid_held", bus.AWVALID, 1);
            check("wr_bready_wait", bus.BREADY, 0);
            tick;
        end
        check("wr_wvalid_low", bus.WVALID, 0);
        bus.AWREADY = 1; tick; bus.AWREADY = 0;
        check("wr_awvalid_drop", bus.AWVALID, 0);
        check("wr_bready", bus.BREADY, 1);
        bus.BVALID = 1; bus.BRESP = 2'b00; tick; bus.BVALID = 0;
        check("wr_rsp_valid", bus.RSP_VALID, 1);
        check("wr_rsp_rdata", bus.RSP_RDATA, 0);
        check("wr_rsp_err", bus.RSP_ERR, 0);
        check("wr_bready_drop", bus.BREADY, 0);
        tick;
        check("wr_rsp_count", rsp_cnt - base, 1);

        // read, ARREADY late by 5 cycles, SLVERR
        request(0, 4'h5, 0, 0);
        repeat (5) begin
            check("slow_arvalid", bus.ARVALID, 1);
            check("slow_araddr", bus.ARADDR, 4'h5);
            check("slow_req_ready", bus.REQ_READY, 0);
            tick;
        end
        bus.ARREADY = 1; tick; bus.ARREADY = 0;
        check("slow_req_ready_rd", bus.REQ_READY, 0);
        bus.RVALID = 1; bus.RDATA = 32'hDEAD_BEEF; bus.RRESP = 2'b10; tick; bus.RVALID = 0;
        check("slow_rsp_valid", bus.RSP_VALID, 1);
        check("slow_rsp_err", bus.RSP_ERR, 1);
        check("slow_rsp_rdata", bus.RSP_RDATA, 32'hDEAD_BEEF);
        check("slow_req_ready_rsp", bus.REQ_READY, 0);
        tick;
        check("slow_req_ready_after", bus.REQ_READY, 1);
        check("slow_err_cleared", bus.RSP_ERR, 0);

        // three reads with REQ_VALID held high throughout
        base = rsp_cnt;
        base_ar = ar_hs;
        bus.REQ_VALID = 1; bus.REQ_WE = 0; bus.REQ_ADDR = 4'hA;
        for (int i = 0; i < 3; i++) begin
            k = 0;
            do begin tick; k++; end while (!bus.ARVALID && k < 10);
            check("b2b_ar_wait", bus.ARVALID, 1);
            bus.ARREADY = 1; tick; bus.ARREADY = 0;
            bus.RVALID = 1; bus.RDATA = 32'h100 + i; bus.RRESP = 2'b01; tick; bus.RVALID = 0;
            check("b2b_rsp_valid", bus.RSP_VALID, 1);
            check("b2b_rsp_rdata", bus.RSP_RDATA, 32'h100 + i);
            check("b2b_exokay", bus.RSP_ERR, 0);
            check("b2b_no_overlap", bus.REQ_READY, 0);
            if (i == 2) bus.REQ_VALID = 0;
        end
        repeat (3) tick;
        check("b2b_ar_handshakes", ar_hs - base_ar, 3);
        check("b2b_rsp_pulses", rsp_cnt - base, 3);

        // reset while waiting for B
        base = rsp_cnt;
        request(1, 4'h2, 32'h11, 4'h3);
        bus.AWREADY = 1; bus.WREADY = 1; tick; bus.AWREADY = 0; bus.WREADY = 0;
        check("rst_mid_bready_pre", bus.BREADY, 1);
        rst = 1; tick; rst = 0;
        check("rst_mid_bready", bus.BREADY, 0);
        check("rst_mid_awvalid", bus.AWVALID, 0);
        check("rst_mid_wvalid", bus.WVALID, 0);
        check("rst_mid_req_ready", bus.REQ_READY, 1);
        check("rst_mid_rsp_valid", bus.RSP_VALID, 0);
        bus.BVALID = 1; bus.BRESP = 2'b00; repeat (3) tick; bus.BVALID = 0;
        check("rst_mid_no_rsp", rsp_cnt - base, 0);

        // ARREADY stuck low
        request(0, 4'h1, 0, 0);
`ifdef IO_AXI_TIMEOUT_EN
        k = 0;
        while (!bus.RSP_VALID && k < 20) begin tick; k++; end
        check("to_rsp_valid", bus.RSP_VALID, 1);
        check("to_latency", k, 8);
        check("to_rsp_err", bus.RSP_ERR, 1);
        check("to_rsp_rdata", bus.RSP_RDATA, 0);
        check("to_arvalid", bus.ARVALID, 0);
        tick;
        check("to_req_ready", bus.REQ_READY, 1);
`else
        k = 0;
        repeat (110) begin
            if (bus.ARVALID && !bus.RSP_VALID) k++;
            tick;
        end
        check("stuck_arvalid_held", k, 110);
        check("stuck_req_ready", bus.REQ_READY, 0);
        rst = 1; tick; rst = 0;
        check("stuck_rst_arvalid", bus.ARVALID, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
